zone_txn_ctrl: RTL and testbench
================================

Name: zone_txn_ctrl

Overview:
- Keypad-driven transaction sequencer for the four-zone space manager.
- Collects an operation (allocate or release), a zone (1-4) and a quantity (1-9), then commits it atomically against per-zone free/used counters.
- All-or-nothing arithmetic: a request that does not fit is rejected with an error code and changes no counter.
- Sits between the keypad edge detector and the display/LED logic, replacing switch-selected direct decrement.

Parameters:
- CAPACITY, 15, per-zone space count at reset; must be <= 2**CNT_W-1.
- CNT_W, 4, width of each free/used counter.
- TIMEOUT_CYC, 500_000_000, idle cycles in a non-IDLE state before abort; 5 s at 100 MHz.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- key_edge  input  16  one-cycle key-press pulses. Bits 9:1 are digits 1-9, bit 0 is digit 0, bit 10 is A (allocate), bit 11 is B (release), bit 12 is C (cancel), bit 13 is D (commit), bits 15:14 are unused.
- free_flat  output  4*CNT_W  free count per zone; zone1 in the LSBs.
- used_flat  output  4*CNT_W  used count per zone; zone1 in the LSBs.
- state_o  output  3  current FSM state encoding, for display.
- op_o  output  1  latched operation: 0 = allocate, 1 = release.
- zone_o  output  2  latched zone minus 1.
- qty_o  output  4  latched quantity; 0 means not yet entered.
- done  output  1  one-cycle pulse on a successful commit.
- err  output  1  one-cycle pulse on reject or timeout.
- err_code  output  2  0 none, 1 no space, 2 underflow, 3 timeout. Held until the next A/B press or reset.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - Every free count = CAPACITY, every used count = 0.
  - State IDLE; op_o, zone_o, qty_o, done, err, err_code all 0; timeout counter 0.
- Key qualification:
  - A key is valid only when exactly one bit of key_edge[13:0] is set.
  - Zero or multiple set bits mean no key: ignored, and the timeout counter is not reset.
- States: IDLE, ZONE, QTY, CONF, COMMIT.
  - IDLE: A sets op=0, B sets op=1; either one clears err_code and qty, then goes to ZONE. All other keys are ignored.
  - ZONE: digit 1-4 latches the zone and goes to QTY. Other digits, A, B and D are ignored.
  - QTY: digit 1-9 latches qty and goes to CONF. Digit 0, A, B and D are ignored.
  - CONF: digit 1-9 overwrites qty and stays in CONF. D goes to COMMIT.
  - C in ZONE, QTY or CONF: go to IDLE, no counter change, no err.
  - COMMIT: unconditional single cycle, ends in IDLE.
    - Allocate: if free[z] >= qty, then free -= qty, used += qty, and done = 1. Otherwise err = 1, err_code = 1.
    - Release: if used[z] >= qty, then used -= qty, free += qty, and done = 1. Otherwise err = 1, err_code = 2.
- Latency: D is sampled at edge k, COMMIT is active during cycle k..k+1, and counters plus done/err update at edge k+1.
- Invariant: free[z] + used[z] == CAPACITY for every zone at all times. Counters never wrap.
- Timeout:
  - The counter increments each cycle in ZONE, QTY or CONF, and clears on any valid key or on entry to IDLE.
  - On reaching TIMEOUT_CYC-1: go to IDLE, pulse err, err_code = 3, no counter change.
  - Timeout takes priority over a key arriving in the same cycle.
- Only the selected zone is modified; other zones hold.
- Reset asserted mid-transaction: immediate return to reset values, and the partial transaction is discarded.

Decomposition:
- Shared package zone_pkg holds:
  - the state enum;
  - key index constants (KEY_A=10, KEY_B=11, KEY_C=12, KEY_D=13);
  - err_code constants (ERR_NONE, ERR_NOSPACE, ERR_UNDER, ERR_TIMEOUT);
  - the NZONE=4 constant.
- One sub-module, key_decode: combinational one-hot check of key_edge, producing key_vld, is_digit, digit[3:0] and is_A/B/C/D.

Test Plan:
- Reset, then A, 2, 5, D -> done pulse one cycle after D; zone2 free = 10, used = 5; other zones free = 15, used = 0.
- After the previous case, A, 2, 9, 7, D -> qty_o = 7 after the overwrite; free2 = 3, used2 = 12.
- Then A, 2, 4, D -> err pulse, err_code = 1, free2 still 3, used2 still 12. Then B, 2, 9, D -> free2 = 12, used2 = 3, err_code = 0.
- After reset, B, 1, 1, D -> err_code = 2, zone1 still 15/0. Then A, 3, C -> IDLE, no done, no err.
- key_edge = bits 1 and 2 together while in ZONE -> ignored, state stays ZONE. A 5 key in ZONE is also ignored.
- A, 4, then no key for TIMEOUT_CYC cycles (TIMEOUT_CYC set to 20 in the bench) -> IDLE, err pulse, err_code = 3. Then assert rst_n low mid-entry -> all outputs return to their reset values.

Source files
------------

// File: rtl/zone_pkg.sv
// Shared types and constants for the four-zone keypad transaction sequencer.
package zone_pkg;

  localparam int NZONE = 4;

  localparam int KEY_A = 10;
  localparam int KEY_B = 11;
  localparam int KEY_C = 12;
  localparam int KEY_D = 13;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NOSPACE = 2'd1;
  localparam logic [1:0] ERR_UNDER   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ZONE   = 3'd1,
    ST_QTY    = 3'd2,
    ST_CONF   = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

endpackage

// File: rtl/zone_txn_ctrl_key_decode.sv
// Combinational key qualifier: a key counts only when exactly one of the 14 key
// lines pulses; chords and idle cycles decode as no key at all.
module key_decode
  import zone_pkg::*;
(
  input  logic [15:0] key_edge_i,
  output logic        key_vld_o,
  output logic        is_digit_o,
  output logic [3:0]  digit_o,
  output logic        is_a_o,
  output logic        is_b_o,
  output logic        is_c_o,
  output logic        is_d_o
);

  logic [1:0] key_unused;
  assign key_unused = key_edge_i[15:14];

  assign key_vld_o  = $onehot(key_edge_i[13:0]);
  assign is_digit_o = key_vld_o & (|key_edge_i[9:0]);
  assign is_a_o     = key_vld_o & key_edge_i[KEY_A];
  assign is_b_o     = key_vld_o & key_edge_i[KEY_B];
  assign is_c_o     = key_vld_o & key_edge_i[KEY_C];
  assign is_d_o     = key_vld_o & key_edge_i[KEY_D];

  // Digit lines map straight to their value; only meaningful with is_digit_o.
  always_comb begin
    digit_o = '0;
    for (int i = 0; i < 10; i++) begin
      if (key_edge_i[i]) digit_o = 4'(i);
    end
  end

endmodule

// File: rtl/zone_txn_ctrl.sv
// Keypad transaction sequencer: collects op/zone/qty and commits it atomically
// against per-zone free/used counters, rejecting requests that would not fit.
module zone_txn_ctrl
  import zone_pkg::*;
#(
  parameter int          CAPACITY    = 15,
  parameter int          CNT_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            key_edge,
  output logic [4*CNT_W-1:0]     free_flat,
  output logic [4*CNT_W-1:0]     used_flat,
  output logic [2:0]             state_o,
  output logic                   op_o,
  output logic [1:0]             zone_o,
  output logic [3:0]             qty_o,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             err_code
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  state_e             state_q, state_d;
  logic               op_q, op_d;
  logic [1:0]         zone_q, zone_d;
  logic [3:0]         qty_q, qty_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   free_q [NZONE];
  logic [CNT_W-1:0]   free_d [NZONE];
  logic [CNT_W-1:0]   used_q [NZONE];
  logic [CNT_W-1:0]   used_d [NZONE];

  logic       key_vld, is_digit, is_a, is_b, is_c, is_d;
  logic [3:0] digit;
  logic [3:0] digit_m1;
  logic       in_entry, tmo_hit;
  logic [CNT_W-1:0] qty_ext;

  key_decode u_key_decode (
    .key_edge_i (key_edge),
    .key_vld_o  (key_vld),
    .is_digit_o (is_digit),
    .digit_o    (digit),
    .is_a_o     (is_a),
    .is_b_o     (is_b),
    .is_c_o     (is_c),
    .is_d_o     (is_d)
  );

  assign digit_m1 = digit - 4'd1;
  assign qty_ext  = CNT_W'(qty_q);
  assign in_entry = (state_q == ST_ZONE) || (state_q == ST_QTY) || (state_q == ST_CONF);
  assign tmo_hit  = in_entry && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  // Timeout wins over any key in the same cycle; commit touches only zone_q.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    zone_d     = zone_q;
    qty_d      = qty_q;
    err_code_d = err_code_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    tmo_d      = '0;
    free_d     = free_q;
    used_d     = used_q;

    if (tmo_hit) begin
      state_d    = ST_IDLE;
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end else begin
      if (in_entry && !key_vld) tmo_d = tmo_q + TMO_W'(1);
      unique case (state_q)
        ST_IDLE: begin
          if (is_a || is_b) begin
            op_d       = is_b;
            err_code_d = ERR_NONE;
            qty_d      = '0;
            state_d    = ST_ZONE;
          end
        end
        ST_ZONE: begin
          if (is_c) begin
            state_d = ST_IDLE;
          end else if (is_digit && digit >= 4'd1 && digit <= 4'd4) begin
            zone_d  = digit_m1[1:0];
            state_d = ST_QTY;
          end
        end
        ST_QTY: begin
          if (is_c) begin
            state_d = ST_IDLE;
          end else if (is_digit && digit != 4'd0) begin
            qty_d   = digit;
            state_d = ST_CONF;
          end
        end
        ST_CONF: begin
          if (is_c) begin
            state_d = ST_IDLE;
          end else if (is_d) begin
            state_d = ST_COMMIT;
          end else if (is_digit && digit != 4'd0) begin
            qty_d = digit;
          end
        end
        ST_COMMIT: begin
          state_d = ST_IDLE;
          if (!op_q) begin
            if (free_q[zone_q] >= qty_ext) begin
              free_d[zone_q] = free_q[zone_q] - qty_ext;
              used_d[zone_q] = used_q[zone_q] + qty_ext;
              done_d         = 1'b1;
            end else begin
              err_d      = 1'b1;
              err_code_d = ERR_NOSPACE;
            end
          end else begin
            if (used_q[zone_q] >= qty_ext) begin
              used_d[zone_q] = used_q[zone_q] - qty_ext;
              free_d[zone_q] = free_q[zone_q] + qty_ext;
              done_d         = 1'b1;
            end else begin
              err_d      = 1'b1;
              err_code_d = ERR_UNDER;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= 1'b0;
      zone_q     <= '0;
      qty_q      <= '0;
      err_code_q <= ERR_NONE;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
      for (int i = 0; i < NZONE; i++) begin
        free_q[i] <= CNT_W'(CAPACITY);
        used_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      zone_q     <= zone_d;
      qty_q      <= qty_d;
      err_code_q <= err_code_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      free_q     <= free_d;
      used_q     <= used_d;
    end
  end

  for (genvar g = 0; g < NZONE; g++) begin : g_flat
    assign free_flat[g*CNT_W +: CNT_W] = free_q[g];
    assign used_flat[g*CNT_W +: CNT_W] = used_q[g];
  end

  assign state_o  = state_q;
  assign op_o     = op_q;
  assign zone_o   = zone_q;
  assign qty_o    = qty_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_zone_txn_ctrl.sv
// Directed bench for zone_txn_ctrl: keys are driven and outputs sampled on the
// falling edge, with every expected value worked out by hand.
module tb_zone_txn_ctrl;

  logic        clk;
  logic        rstN;
  logic [15:0] keyEdge;
  logic [15:0] freeFlat;
  logic [15:0] usedFlat;
  logic [2:0]  stateO;
  logic        opO;
  logic [1:0]  zoneO;
  logic [3:0]  qtyO;
  logic        done;
  logic        err;
  logic [1:0]  errCode;

  int cmpCount;
  int badCount;

  zone_txn_ctrl #(
    .CAPACITY    (15),
    .CNT_W       (4),
    .TIMEOUT_CYC (20)
  ) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .key_edge  (keyEdge),
    .free_flat (freeFlat),
    .used_flat (usedFlat),
    .state_o   (stateO),
    .op_o      (opO),
    .zone_o    (zoneO),
    .qty_o     (qtyO),
    .done      (done),
    .err       (err),
    .err_code  (errCode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle pulse on a single key line, sampled by the rising edge in between.
  task automatic applyStimulus(input int k);
    @(negedge clk);
    keyEdge = '0;
    keyEdge[k] = 1'b1;
    @(negedge clk);
    keyEdge = '0;
  endtask

  task automatic applyRaw(input logic [15:0] v);
    @(negedge clk);
    keyEdge = v;
    @(negedge clk);
    keyEdge = '0;
  endtask

  task automatic doReset();
    keyEdge = '0;
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    doReset();
    cmpCount++; if (stateO !== 3'd0) begin badCount++; $display("[TB] FAIL reset_state got=%0d want=0", stateO); end
    cmpCount++; if ({opO, zoneO, qtyO} !== 7'd0) begin badCount++; $display("[TB] FAIL reset_latches got=%h want=0", {opO, zoneO, qtyO}); end
    cmpCount++; if ({done, err, errCode} !== 4'd0) begin badCount++; $display("[TB] FAIL reset_flags got=%h want=0", {done, err, errCode}); end
    cmpCount++; if (freeFlat !== 16'hFFFF) begin badCount++; $display("[TB] FAIL reset_free got=%h want=ffff", freeFlat); end
    cmpCount++; if (usedFlat !== 16'h0000) begin badCount++; $display("[TB] FAIL reset_used got=%h want=0000", usedFlat); end
  endtask

  task automatic test_alloc();
    applyStimulus(10); applyStimulus(2); applyStimulus(5);
    cmpCount++; if (stateO !== 3'd3) begin badCount++; $display("[TB] FAIL alloc_conf_state got=%0d want=3", stateO); end
    cmpCount++; if ({opO, zoneO, qtyO} !== {1'b0, 2'd1, 4'd5}) begin badCount++; $display("[TB] FAIL alloc_latches got=%h want=%h", {opO, zoneO, qtyO}, {1'b0, 2'd1, 4'd5}); end
    applyStimulus(13);
    cmpCount++; if ({stateO, done} !== {3'd4, 1'b0}) begin badCount++; $display("[TB] FAIL alloc_commit_state got=%h want=%h", {stateO, done}, {3'd4, 1'b0}); end
    @(negedge clk);
    cmpCount++; if ({done, err} !== 2'b10) begin badCount++; $display("[TB] FAIL alloc_done got=%b want=10", {done, err}); end
    cmpCount++; if (freeFlat !== 16'hFFAF) begin badCount++; $display("[TB] FAIL alloc_free got=%h want=ffaf", freeFlat); end
    cmpCount++; if (usedFlat !== 16'h0050) begin badCount++; $display("[TB] FAIL alloc_used got=%h want=0050", usedFlat); end
    cmpCount++; if (stateO !== 3'd0) begin badCount++; $display("[TB] FAIL alloc_idle got=%0d want=0", stateO); end
    @(negedge clk);
    cmpCount++; if (done !== 1'b0) begin badCount++; $display("[TB] FAIL alloc_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_overwrite();
    applyStimulus(10); applyStimulus(2); applyStimulus(9); applyStimulus(7);
    cmpCount++; if ({stateO, qtyO} !== {3'd3, 4'd7}) begin badCount++; $display("[TB] FAIL ovw_qty got=%h want=%h", {stateO, qtyO}, {3'd3, 4'd7}); end
    applyStimulus(13);
    @(negedge clk);
    cmpCount++; if (done !== 1'b1) begin badCount++; $display("[TB] FAIL ovw_done got=%b want=1", done); end
    cmpCount++; if ({freeFlat, usedFlat} !== {16'hFF3F, 16'h00C0}) begin badCount++; $display("[TB] FAIL ovw_counts got=%h want=ff3f00c0", {freeFlat, usedFlat}); end
  endtask

  task automatic test_nospace();
    applyStimulus(10); applyStimulus(2); applyStimulus(4); applyStimulus(13);
    @(negedge clk);
    cmpCount++; if ({done, err, errCode} !== {1'b0, 1'b1, 2'd1}) begin badCount++; $display("[TB] FAIL nospace_flags got=%b want=0101", {done, err, errCode}); end
    cmpCount++; if ({freeFlat, usedFlat} !== {16'hFF3F, 16'h00C0}) begin badCount++; $display("[TB] FAIL nospace_counts got=%h want=ff3f00c0", {freeFlat, usedFlat}); end
    @(negedge clk);
    cmpCount++; if ({err, errCode} !== {1'b0, 2'd1}) begin badCount++; $display("[TB] FAIL nospace_hold got=%b want=001", {err, errCode}); end
  endtask

  task automatic test_release();
    applyStimulus(11);
    cmpCount++; if ({opO, errCode, qtyO} !== {1'b1, 2'd0, 4'd0}) begin badCount++; $display("[TB] FAIL rel_start got=%h want=%h", {opO, errCode, qtyO}, {1'b1, 2'd0, 4'd0}); end
    applyStimulus(2); applyStimulus(9); applyStimulus(13);
    @(negedge clk);
    cmpCount++; if ({done, err, errCode} !== 4'b1000) begin badCount++; $display("[TB] FAIL rel_flags got=%b want=1000", {done, err, errCode}); end
    cmpCount++; if ({freeFlat, usedFlat} !== {16'hFFCF, 16'h0030}) begin badCount++; $display("[TB] FAIL rel_counts got=%h want=ffcf0030", {freeFlat, usedFlat}); end
  endtask

  task automatic test_underflow_cancel();
    doReset();
    applyStimulus(11); applyStimulus(1); applyStimulus(1); applyStimulus(13);
    @(negedge clk);
    cmpCount++; if ({done, err, errCode} !== {1'b0, 1'b1, 2'd2}) begin badCount++; $display("[TB] FAIL under_flags got=%b want=0110", {done, err, errCode}); end
    cmpCount++; if ({freeFlat, usedFlat} !== {16'hFFFF, 16'h0000}) begin badCount++; $display("[TB] FAIL under_counts got=%h want=ffff0000", {freeFlat, usedFlat}); end
    applyStimulus(10); applyStimulus(3);
    cmpCount++; if ({stateO, zoneO} !== {3'd2, 2'd2}) begin badCount++; $display("[TB] FAIL cancel_pre got=%h want=%h", {stateO, zoneO}, {3'd2, 2'd2}); end
    applyStimulus(12);
    cmpCount++; if ({stateO, done, err, errCode} !== {3'd0, 1'b0, 1'b0, 2'd0}) begin badCount++; $display("[TB] FAIL cancel_idle got=%b want=0000000", {stateO, done, err, errCode}); end
    @(negedge clk);
    cmpCount++; if ({done, err, freeFlat} !== {2'b00, 16'hFFFF}) begin badCount++; $display("[TB] FAIL cancel_after got=%h want=0ffff", {done, err, freeFlat}); end
  endtask

  task automatic test_ignore();
    applyStimulus(10);
    applyRaw(16'h0006);
    cmpCount++; if (stateO !== 3'd1) begin badCount++; $display("[TB] FAIL chord_ignored got=%0d want=1", stateO); end
    applyStimulus(5);
    cmpCount++; if (stateO !== 3'd1) begin badCount++; $display("[TB] FAIL zone5_ignored got=%0d want=1", stateO); end
    applyStimulus(13); applyStimulus(0); applyStimulus(11);
    cmpCount++; if ({stateO, opO} !== {3'd1, 1'b0}) begin badCount++; $display("[TB] FAIL zone_misc_ignored got=%h want=%h", {stateO, opO}, {3'd1, 1'b0}); end
    applyStimulus(4);
    cmpCount++; if ({stateO, zoneO} !== {3'd2, 2'd3}) begin badCount++; $display("[TB] FAIL zone4_taken got=%h want=%h", {stateO, zoneO}, {3'd2, 2'd3}); end
    applyStimulus(12);
  endtask

  task automatic test_timeout();
    applyStimulus(10); applyStimulus(4);
    repeat (19) @(negedge clk);
    cmpCount++; if ({stateO, err} !== {3'd2, 1'b0}) begin badCount++; $display("[TB] FAIL tmo_early got=%h want=%h", {stateO, err}, {3'd2, 1'b0}); end
    @(negedge clk);
    cmpCount++; if ({stateO, err, errCode} !== {3'd0, 1'b1, 2'd3}) begin badCount++; $display("[TB] FAIL tmo_fire got=%b want=000111", {stateO, err, errCode}); end
    cmpCount++; if ({freeFlat, usedFlat} !== {16'hFFFF, 16'h0000}) begin badCount++; $display("[TB] FAIL tmo_counts got=%h want=ffff0000", {freeFlat, usedFlat}); end
    @(negedge clk);
    cmpCount++; if ({err, errCode} !== {1'b0, 2'd3}) begin badCount++; $display("[TB] FAIL tmo_hold got=%b want=011", {err, errCode}); end
  endtask

  task automatic test_reset_mid();
    applyStimulus(10); applyStimulus(1); applyStimulus(3); applyStimulus(13);
    @(negedge clk);
    cmpCount++; if ({freeFlat, usedFlat} !== {16'hFFFC, 16'h0003}) begin badCount++; $display("[TB] FAIL mid_pre_counts got=%h want=fffc0003", {freeFlat, usedFlat}); end
    applyStimulus(11); applyStimulus(2); applyStimulus(7);
    #2 rstN = 1'b0;
    #1;
    cmpCount++; if ({stateO, opO, zoneO, qtyO} !== 10'd0) begin badCount++; $display("[TB] FAIL mid_rst_latches got=%h want=0", {stateO, opO, zoneO, qtyO}); end
    cmpCount++; if ({freeFlat, usedFlat} !== {16'hFFFF, 16'h0000}) begin badCount++; $display("[TB] FAIL mid_rst_counts got=%h want=ffff0000", {freeFlat, usedFlat}); end
    cmpCount++; if ({done, err, errCode} !== 4'd0) begin badCount++; $display("[TB] FAIL mid_rst_flags got=%b want=0000", {done, err, errCode}); end
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    cmpCount = 0;
    badCount = 0;
    keyEdge  = '0;
    rstN     = 1'b1;
    test_reset();
    test_alloc();
    test_overwrite();
    test_nospace();
    test_release();
    test_underflow_cancel();
    test_ignore();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, badCount);
    $finish;
  end

endmodule
